clip_expand: RTL

//  Inverse of the FFT datapath clipping stage. Takes a stream of symmetric-saturated OL-bit complex samples
//  and their per-frame block exponent, and restores IL-bit words for the next wide-datapath stage.

---
 rtl/clip_expand_pkg.sv | 17 +
 rtl/clip_expand_sat_shift.sv | 41 ++++
 rtl/clip_expand.sv | 125 ++++++++++++
 3 files changed

// File: rtl/clip_expand_pkg.sv
// Shared word-length defaults and symmetric saturation limits for the FFT datapath.
package clip_expand_pkg;

  localparam int IL_DEF  = 10;
  localparam int OL_DEF  = 8;
  localparam int EW_DEF  = 3;
  localparam int NPT_DEF = 64;

  function automatic int smax(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int smin(input int w);
    return -smax(w);
  endfunction

endpackage

// File: rtl/clip_expand_sat_shift.sv
// Combinational arithmetic left shift of an IL-bit word with symmetric saturation to IL bits.
module sat_shift
  import clip_expand_pkg::*;
#(
  parameter int IL = IL_DEF,
  parameter int OL = OL_DEF,
  parameter int EW = EW_DEF
) (
  input  logic [IL-1:0] iD,
  input  logic [EW-1:0] iSH,
  output logic [IL-1:0] oD,
  output logic          oSAT
);

  localparam int SW = IL + (1 << EW) - 1;
  localparam logic signed [SW-1:0] POS_LIM = SW'(smax(IL));
  localparam logic signed [SW-1:0] NEG_LIM = SW'(smin(IL));

  if (IL <= OL) begin : g_width_chk
    $error("sat_shift: IL must exceed OL");
  end

  logic signed [SW-1:0] ext;
  logic signed [SW-1:0] s;

  // Wide enough for the largest shift, so the comparisons see the true value.
  always_comb begin
    ext  = {{(SW-IL){iD[IL-1]}}, iD};
    s    = ext <<< iSH;
    oD   = s[IL-1:0];
    oSAT = 1'b0;
    if (s > POS_LIM) begin
      oD   = POS_LIM[IL-1:0];
      oSAT = 1'b1;
    end else if (s < NEG_LIM) begin
      oD   = NEG_LIM[IL-1:0];
      oSAT = 1'b1;
    end
  end

endmodule

// File: rtl/clip_expand.sv
// Expands OL-bit clipped complex samples back to IL bits using the per-frame block exponent.
module clip_expand
  import clip_expand_pkg::*;
#(
  parameter int IL  = IL_DEF,
  parameter int OL  = OL_DEF,
  parameter int EW  = EW_DEF,
  parameter int NPT = NPT_DEF
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          iVALID,
  output logic          oREADY,
  input  logic [OL-1:0] iDATA_RE,
  input  logic [OL-1:0] iDATA_IM,
  input  logic [EW-1:0] iEXP,
  input  logic          iERR_CLR,
  output logic          oVALID,
  input  logic          iREADY,
  output logic [IL-1:0] oDATA_RE,
  output logic [IL-1:0] oDATA_IM,
  output logic          oSOF,
  output logic          oEOF,
  output logic          oOVF,
  output logic          oMINMAX_ERR
);

  localparam int CW = $clog2(NPT);
  localparam logic [OL-1:0] IN_MIN  = {1'b1, {(OL-1){1'b0}}};
  localparam logic [OL-1:0] IN_CLIP = IN_MIN + OL'(1);

  logic          en, in_beat, first;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [EW-1:0] exp_q, exp_d;
  logic          err_q, err_d;
  logic [OL-1:0] re_c, im_c;
  logic          mm_in;

  logic          v1_q, sof1_q, eof1_q, mm1_q;
  logic [EW-1:0] exp1_q;
  logic [IL-1:0] re1_q, im1_q;

  logic          v2_q, sof2_q, eof2_q, ovf2_q;
  logic [IL-1:0] re2_q, im2_q;

  logic [IL-1:0] re_s, im_s;
  logic          re_sat, im_sat;

  assign en      = ~v2_q | iREADY;
  assign in_beat = iVALID & en;
  assign first   = (cnt_q == '0);

  always_comb begin
    mm_in = (iDATA_RE == IN_MIN) | (iDATA_IM == IN_MIN);
    re_c  = (iDATA_RE == IN_MIN) ? IN_CLIP : iDATA_RE;
    im_c  = (iDATA_IM == IN_MIN) ? IN_CLIP : iDATA_IM;
    cnt_d = in_beat ? cnt_q + CW'(1) : cnt_q;
    exp_d = (in_beat && first) ? iEXP : exp_q;
    // A set in the same cycle as a clear takes priority.
    err_d = (en & v1_q & mm1_q) | (err_q & ~iERR_CLR);
  end

  sat_shift #(.IL(IL), .OL(OL), .EW(EW)) u_sat_re (
    .iD(re1_q), .iSH(exp1_q), .oD(re_s), .oSAT(re_sat)
  );

  sat_shift #(.IL(IL), .OL(OL), .EW(EW)) u_sat_im (
    .iD(im1_q), .iSH(exp1_q), .oD(im_s), .oSAT(im_sat)
  );

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      cnt_q  <= '0;
      exp_q  <= '0;
      err_q  <= 1'b0;
      v1_q   <= 1'b0;
      sof1_q <= 1'b0;
      eof1_q <= 1'b0;
      mm1_q  <= 1'b0;
      exp1_q <= '0;
      re1_q  <= '0;
      im1_q  <= '0;
      v2_q   <= 1'b0;
      sof2_q <= 1'b0;
      eof2_q <= 1'b0;
      ovf2_q <= 1'b0;
      re2_q  <= '0;
      im2_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      exp_q <= exp_d;
      err_q <= err_d;
      if (en) begin
        v1_q <= iVALID;
        if (iVALID) begin
          sof1_q <= first;
          eof1_q <= (cnt_q == CW'(NPT - 1));
          mm1_q  <= mm_in;
          // The exponent travels with the sample so a frame boundary never mixes exponents.
          exp1_q <= first ? iEXP : exp_q;
          re1_q  <= {{(IL-OL){re_c[OL-1]}}, re_c};
          im1_q  <= {{(IL-OL){im_c[OL-1]}}, im_c};
        end
        v2_q   <= v1_q;
        sof2_q <= v1_q & sof1_q;
        eof2_q <= v1_q & eof1_q;
        ovf2_q <= v1_q & (re_sat | im_sat);
        if (v1_q) begin
          re2_q <= re_s;
          im2_q <= im_s;
        end
      end
    end
  end

  assign oREADY      = en;
  assign oVALID      = v2_q;
  assign oDATA_RE    = re2_q;
  assign oDATA_IM    = im2_q;
  assign oSOF        = sof2_q;
  assign oEOF        = eof2_q;
  assign oOVF        = ovf2_q;
  assign oMINMAX_ERR = err_q;

endmodule
